// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter for the pipelined MIPS core.
//   Keeps the PC register and picks the next PC by fixed priority:
//   Exception > Eret > JumpReg > Branch > Jump > held redirect > PC+INC.
//   A redirect that arrives during a stall is held until Write returns.
//   Also holds a small circular return-address stack (RAS) that fetch
//   uses to predict `jr $ra`.
// Ports:
//   Clk, Reset (async, active low)
//   Write                      : PC update enable (0 = stall)
//   Exception/ExcPC, Eret      : exception entry / return
//   JumpReg/RegTarget, Branch/BranchTarget, Jump/JumpTarget : redirects
//   Link/LinkAddr, Return      : RAS push / pop
//   PCResult, PCPlus, EPC, Pending, RasTop, RasValid : status outputs
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Write,
  input  logic             Exception,
  input  logic [WIDTH-1:0] ExcPC,
  input  logic             Eret,
  input  logic             JumpReg,
  input  logic [WIDTH-1:0] RegTarget,
  input  logic             Branch,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Link,
  input  logic [WIDTH-1:0] LinkAddr,
  input  logic             Return,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCPlus,
  output logic [WIDTH-1:0] EPC,
  output logic             Pending,
  output logic [WIDTH-1:0] RasTop,
  output logic             RasValid
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_pend;
  logic [WIDTH-1:0] r_pend_tgt;

  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [PW:0]      r_cnt;

  logic             w_redir;
  logic [WIDTH-1:0] w_redir_tgt;
  logic [WIDTH-1:0] w_pc_plus;
  logic [PW-1:0]    w_top_idx;
  logic             w_ras_empty;
  logic             w_ras_full;

  assign w_pc_plus = r_pc + WIDTH'(INC);
  assign w_redir   = JumpReg | Branch | Jump;

  always_comb begin
    w_redir_tgt = JumpTarget;
    if (JumpReg)     w_redir_tgt = RegTarget;
    else if (Branch) w_redir_tgt = BranchTarget;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc       <= RESET_VECTOR;
      r_epc      <= '0;
      r_pend     <= 1'b0;
      r_pend_tgt <= '0;
    end else if (Exception) begin
      r_pc   <= EXC_VECTOR;
      r_epc  <= ExcPC;
      r_pend <= 1'b0;
    end else if (Eret) begin
      r_pc   <= r_epc;
      r_pend <= 1'b0;
    end else if (Write) begin
      if (w_redir)     r_pc <= w_redir_tgt;
      else if (r_pend) r_pc <= r_pend_tgt;
      else             r_pc <= w_pc_plus;
      r_pend <= 1'b0;
    end else if (w_redir) begin
      // a newer stalled redirect replaces any older held one
      r_pend_tgt <= w_redir_tgt;
      r_pend     <= 1'b1;
    end
  end

  // RAS: r_ptr points at the next free slot, top of stack is r_ptr-1.
  assign w_top_idx   = r_ptr - PW'(1);
  assign w_ras_empty = (r_cnt == '0);
  assign w_ras_full  = (r_cnt == (PW+1)'(RAS_DEPTH));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (Link && Return && !w_ras_empty) begin
      r_ras[w_top_idx] <= LinkAddr;
    end else if (Link) begin
      // when full the oldest slot is the one ptr lands on, so it is overwritten
      r_ras[r_ptr] <= LinkAddr;
      r_ptr        <= r_ptr + PW'(1);
      if (!w_ras_full) r_cnt <= r_cnt + (PW+1)'(1);
    end else if (Return && !w_ras_empty) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - (PW+1)'(1);
    end
  end

  assign PCResult = r_pc;
  assign PCPlus   = w_pc_plus;
  assign EPC      = r_epc;
  assign Pending  = r_pend;
  assign RasValid = !w_ras_empty;
  assign RasTop   = w_ras_empty ? '0 : r_ras[w_top_idx];

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [7:0] W = 8'h80, X = 8'h40, E = 8'h20, R = 8'h10,
                         B = 8'h08, J = 8'h04, L = 8'h02, P = 8'h01;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        pend;
    logic [31:0] top;
    logic        valid;
  } exp_t;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] excpc, regt, brt, jt, linka;
    exp_t        ex;
  } vec_t;

  logic        Clk = 0, Reset = 0;
  logic        Write = 0, Exception = 0, Eret = 0, JumpReg = 0, Branch = 0, Jump = 0;
  logic        Link = 0, Return = 0;
  logic [31:0] ExcPC = 0, RegTarget = 0, BranchTarget = 0, JumpTarget = 0, LinkAddr = 0;
  logic [31:0] PCResult, PCPlus, EPC, RasTop;
  logic        Pending, RasValid;

  int total = 0, bad = 0;
  exp_t sbq[$];
  vec_t tbl[37];

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Write(Write), .Exception(Exception), .ExcPC(ExcPC),
    .Eret(Eret), .JumpReg(JumpReg), .RegTarget(RegTarget), .Branch(Branch),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .Link(Link), .LinkAddr(LinkAddr), .Return(Return),
    .PCResult(PCResult), .PCPlus(PCPlus), .EPC(EPC), .Pending(Pending),
    .RasTop(RasTop), .RasValid(RasValid)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(logic [7:0] c, logic [31:0] xp, logic [31:0] rt,
                              logic [31:0] bt, logic [31:0] jt, logic [31:0] la,
                              logic [31:0] pc, logic [31:0] epc, logic pend,
                              logic [31:0] top, logic valid);
    vec_t v;
    v.ctrl = c; v.excpc = xp; v.regt = rt; v.brt = bt; v.jt = jt; v.linka = la;
    v.ex.pc = pc; v.ex.epc = epc; v.ex.pend = pend; v.ex.top = top; v.ex.valid = valid;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, exp_t e);
    chk({tag, " pc"}, PCResult, e.pc);
    chk({tag, " pcplus"}, PCPlus, e.pc + 32'd4);
    chk({tag, " epc"}, EPC, e.epc);
    chk({tag, " pending"}, {31'd0, Pending}, {31'd0, e.pend});
    chk({tag, " rastop"}, RasTop, e.top);
    chk({tag, " rasvalid"}, {31'd0, RasValid}, {31'd0, e.valid});
  endtask

  task automatic drive(vec_t v);
    {Write, Exception, Eret, JumpReg, Branch, Jump, Link, Return} = v.ctrl;
    ExcPC = v.excpc; RegTarget = v.regt; BranchTarget = v.brt;
    JumpTarget = v.jt; LinkAddr = v.linka;
  endtask

  task automatic run_vec(string tag, vec_t v);
    exp_t e;
    @(negedge Clk);
    drive(v);
    sbq.push_back(v.ex);
    @(posedge Clk);
    #1;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
    end else begin
      e = sbq.pop_front();
      chk_all(tag, e);
    end
  endtask

  initial begin
    exp_t e0;
    // sequential fetch
    tbl[0]  = mk(W, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0, 0);
    tbl[1]  = mk(W, 0, 0, 0, 0, 0, 32'h8, 0, 0, 0, 0);
    tbl[2]  = mk(W, 0, 0, 0, 0, 0, 32'hC, 0, 0, 0, 0);
    tbl[3]  = mk(W, 0, 0, 0, 0, 0, 32'h10, 0, 0, 0, 0);
    // redirect priority, exception, eret
    tbl[4]  = mk(W|R|B|J, 0, 32'h200, 32'h300, 32'h500, 0, 32'h200, 0, 0, 0, 0);
    tbl[5]  = mk(W|X|E, 32'h204, 0, 0, 0, 0, 32'h80, 32'h204, 0, 0, 0);
    tbl[6]  = mk(E, 0, 0, 0, 0, 0, 32'h204, 32'h204, 0, 0, 0);
    // stalled branch held, then released
    tbl[7]  = mk(B, 0, 0, 32'h400, 0, 0, 32'h204, 32'h204, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 32'h204, 32'h204, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 32'h204, 32'h204, 1, 0, 0);
    tbl[10] = mk(W, 0, 0, 0, 0, 0, 32'h400, 32'h204, 0, 0, 0);
    // exception during a stall discards the held redirect
    tbl[11] = mk(J, 0, 0, 0, 32'h600, 0, 32'h400, 32'h204, 1, 0, 0);
    tbl[12] = mk(X, 32'h404, 0, 0, 0, 0, 32'h80, 32'h404, 0, 0, 0);
    tbl[13] = mk(W, 0, 0, 0, 0, 0, 32'h84, 32'h404, 0, 0, 0);
    // newer stalled redirect overwrites older
    tbl[14] = mk(B, 0, 0, 32'h700, 0, 0, 32'h84, 32'h404, 1, 0, 0);
    tbl[15] = mk(J, 0, 0, 0, 32'h800, 0, 32'h84, 32'h404, 1, 0, 0);
    tbl[16] = mk(W, 0, 0, 0, 0, 0, 32'h800, 32'h404, 0, 0, 0);
    // wrap at top of address space
    tbl[17] = mk(W|J, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h404, 0, 0, 0);
    tbl[18] = mk(W, 0, 0, 0, 0, 0, 32'h0, 32'h404, 0, 0, 0);
    // RAS push past full, pops, pop when empty
    tbl[19] = mk(L, 0, 0, 0, 0, 32'h10, 0, 32'h404, 0, 32'h10, 1);
    tbl[20] = mk(L, 0, 0, 0, 0, 32'h20, 0, 32'h404, 0, 32'h20, 1);
    tbl[21] = mk(L, 0, 0, 0, 0, 32'h30, 0, 32'h404, 0, 32'h30, 1);
    tbl[22] = mk(L, 0, 0, 0, 0, 32'h40, 0, 32'h404, 0, 32'h40, 1);
    tbl[23] = mk(L, 0, 0, 0, 0, 32'h50, 0, 32'h404, 0, 32'h50, 1);
    tbl[24] = mk(P, 0, 0, 0, 0, 0, 0, 32'h404, 0, 32'h40, 1);
    tbl[25] = mk(P, 0, 0, 0, 0, 0, 0, 32'h404, 0, 32'h30, 1);
    tbl[26] = mk(P, 0, 0, 0, 0, 0, 0, 32'h404, 0, 32'h20, 1);
    tbl[27] = mk(P, 0, 0, 0, 0, 0, 0, 32'h404, 0, 32'h0, 0);
    tbl[28] = mk(P, 0, 0, 0, 0, 0, 0, 32'h404, 0, 32'h0, 0);
    // simultaneous link/return
    tbl[29] = mk(L, 0, 0, 0, 0, 32'h10, 0, 32'h404, 0, 32'h10, 1);
    tbl[30] = mk(L, 0, 0, 0, 0, 32'h20, 0, 32'h404, 0, 32'h20, 1);
    tbl[31] = mk(L|P, 0, 0, 0, 0, 32'h99, 0, 32'h404, 0, 32'h99, 1);
    tbl[32] = mk(P, 0, 0, 0, 0, 0, 0, 32'h404, 0, 32'h10, 1);
    tbl[33] = mk(P, 0, 0, 0, 0, 0, 0, 32'h404, 0, 32'h0, 0);
    tbl[34] = mk(L|P, 0, 0, 0, 0, 32'h55, 0, 32'h404, 0, 32'h55, 1);
    tbl[35] = mk(P, 0, 0, 0, 0, 0, 0, 32'h404, 0, 32'h0, 0);
    // setup for async reset check: pc moves, then two RAS pushes
    tbl[36] = mk(W|L, 0, 0, 0, 0, 32'h11, 32'h4, 32'h404, 0, 32'h11, 1);

    // reset state, before any clock edge is sampled
    #2;
    e0.pc = 0; e0.epc = 0; e0.pend = 0; e0.top = 0; e0.valid = 0;
    chk_all("reset", e0);
    @(negedge Clk);
    Reset = 1;

    for (int i = 0; i < 37; i++) run_vec($sformatf("v%0d", i), tbl[i]);

    // second push and a stalled branch, then async reset mid-cycle
    run_vec("s0", mk(L, 0, 0, 0, 0, 32'h22, 32'h4, 32'h404, 0, 32'h22, 1));
    run_vec("s1", mk(B, 0, 0, 32'h900, 0, 0, 32'h4, 32'h404, 1, 32'h22, 1));
    @(negedge Clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    Reset = 0;
    #1;
    chk_all("async_rst", e0);
    @(negedge Clk);
    Reset = 1;
    // held redirect must be gone: sequential step from reset vector
    run_vec("post_rst", mk(W, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0, 0));

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
